seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial pattern detector, the next generation of the fixed 1100 sequence detector. It matches a runtime-programmable pattern of up to PAT_W bits on a 1-bit qualified input stream, with selectable overlapping or non-overlapping detection. The match output is Mealy, asserted in the same cycle as the completing bit. An optional saturating match counter can be compiled in. The block sits on the serial-input side of the design, alongside the other sequence detectors and generators.

## Interface
- PAT_W, 4: maximum pattern length in bits; minimum 2.
- CNT_W, 8: match counter width.
- RST_PAT, 4'b1100 (PAT_W bits): pattern loaded at reset.
- RST_LEN, 4: pattern length loaded at reset.
- RST_OVL, 1: overlap mode loaded at reset.
- LEN_W: derived, $clog2(PAT_W+1).

- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in, input, 1: serial data bit.
- in_valid, input, 1: `in` is consumed on any edge where in_valid=1.
- cfg_load, input, 1: latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, PAT_W: new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len, input, LEN_W: new pattern length.
- cfg_overlap, input, 1: 1 selects overlapping detection; 0 selects non-overlapping.
- cnt_clr, input, 1: synchronous clear of match_cnt.
- y, output, 1: combinational match indication.
- match_cnt, output, CNT_W: saturating count of matches.

## Operation
- Registered state:
  - pat_r, len_r, ovl_r: active configuration.
  - hist: previous PAT_W-1 accepted bits; newest bit in the LSB.
  - fill: number of valid bits in hist, 0..PAT_W-1, saturating.
  - match_cnt.
- Effective length L:
  - cfg_len=0 is stored as PAT_W.
  - cfg_len>PAT_W is clamped to PAT_W.
  - L=1 is legal; it matches the single bit pat_r[0].
- y = in_valid & ~cfg_load & (fill >= L-1) & ({hist,in}[L-1:0] == pat_r[L-1:0]).
- On an accepted bit (in_valid=1, cfg_load=0):
  - hist <= {hist[PAT_W-3:0], in}.
  - fill <= min(fill+1, PAT_W-1).
  - If y=1 and ovl_r=0: fill <= 0, so the next match needs L fresh bits.
  - If ovl_r=1: history is retained, so matches may share bits.
- cfg_load:
  - Latches the configuration and clears fill to 0. hist contents are don't-care.
  - It takes priority over in_valid in the same cycle: that bit is dropped and y=0.
  - match_cnt is unaffected.
- match_cnt (when compiled in):
  - Increments when y=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr wins over a simultaneous match, giving 0.
- in_valid=0: no state change and y=0. Gaps between bits do not break a sequence.

## Timing
- Reset values:
  - pat_r=RST_PAT, len_r=RST_LEN (clamped), ovl_r=RST_OVL.
  - hist=0, fill=0, match_cnt=0.
  - y=0, because fill=0 blocks matches when L>1.
- y has zero latency: it is asserted combinationally in the cycle carrying the final pattern bit and is valid before the clock edge.
- match_cnt updates on the edge that consumes the matching bit, so it is visible one cycle after y.
- A new configuration applies starting with the first bit after the cfg_load edge.
- Reset asserted mid-sequence clears the partial match immediately (asynchronous). After release, a full L bits are needed for the next match.
- Reset release is treated as synchronous to clk by the integrator.

## Configuration
- Macro SEQ_DETECT_CNT_EN.
- Defined: match_cnt register, saturation and cnt_clr logic are present as described.
- Undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are built. y behaviour is identical in both builds.

## Structure
- Package seq_pkg holds:
  - Overlap-mode constants SEQ_OVL and SEQ_NOVL.
  - The default pattern constant (4'b1100).
  - The length clamp function (maps 0 or >PAT_W to PAT_W).
- Sub-module seq_hist_reg:
  - Contains the hist shift register and the fill counter, with shift, clear and nonoverlap-reset controls.
  - Is reused by future generator blocks.
- The top level holds the configuration registers, the masked compare, y and match_cnt.

## Test plan
1. Reset defaults, in_valid=1 every cycle, stream 1,1,0,0,1,1,0,0 → y=1 on bits 3 and 7 only; match_cnt=2 afterwards.
2. Load pattern 3'b101, L=3, ovl=1; stream 1,0,1,0,1 → y on bits 2 and 4. Repeat with ovl=0 → y on bit 2 only.
3. Stream 1,1,0 with in_valid low for 3 cycles between bits, then 0 → y=1 on the final bit. Drive in_valid=0 with in toggling → y stays 0.
4. Load issued after bits 1,1,0 of 1100, followed by bit 0 → no match. cfg_load together with in_valid=1 → y=0 and the bit is ignored.
5. CNT_W=2, six consecutive matches → match_cnt stops at 3. cnt_clr together with a match → 0. Build without SEQ_DETECT_CNT_EN → match_cnt always 0.
6. Assert rst asynchronously after 1,1,0 → fill, hist and match_cnt cleared before the next edge. After release, 0 followed by 1,1,0,0 → one match, on the last bit.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and length clamp for the sequence detector family
package seq_pkg;

  typedef enum logic {
    SEQ_NOVL = 1'b0,
    SEQ_OVL  = 1'b1
  } seq_ovl_e;

  localparam logic [3:0] SEQ_DEF_PAT = 4'b1100;

  // A length of 0 or anything beyond the pattern register means "use the whole register".
  function automatic int unsigned seq_clamp_len(input int unsigned len, input int unsigned pat_w);
    if (len == 0 || len > pat_w) begin
      return pat_w;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_hist_reg.sv
// rtl/seq_hist_reg.sv - serial history shift register with saturating fill count
module seq_hist_reg #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             novl_clr,
  input  logic             bit_in,
  output logic [PAT_W-2:0] hist,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);
  localparam logic [LEN_W-1:0] FILL_ONE = LEN_W'(1);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-2:0] shifted;

  generate
    if (PAT_W == 2) begin : g_one_bit
      assign shifted = bit_in;
    end else begin : g_multi_bit
      assign shifted = {hist_q[PAT_W-3:0], bit_in};
    end
  endgenerate

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = shifted;
      if (novl_clr) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - programmable serial pattern detector, Mealy match output
// Optional saturating match counter built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = SEQ_DEF_PAT,
  parameter int               RST_LEN = 4,
  parameter bit               RST_OVL = 1'b1,
  parameter int               LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] RST_L   = LEN_W'(seq_clamp_len(RST_LEN, PAT_W));
  localparam logic [LEN_W:0]   LEN_ONE = (LEN_W + 1)'(1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  seq_ovl_e         ovl_q, ovl_d;

  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic             accept;
  logic             fill_ok;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             novl_clr;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = LEN_W'(seq_clamp_len(32'(cfg_len), PAT_W));
      ovl_d = seq_ovl_e'(cfg_overlap);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= RST_PAT;
      len_q <= RST_L;
      ovl_q <= seq_ovl_e'(RST_OVL);
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
    end
  end

  // A bit arriving with cfg_load is dropped, so it neither matches nor shifts.
  assign accept = in_valid & ~cfg_load;
  assign window = {hist, in};

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // fill >= L-1, written as fill+1 >= L to stay unsigned-safe.
  assign fill_ok  = ({1'b0, fill} + LEN_ONE) >= {1'b0, len_q};
  assign y        = accept & fill_ok & (((window ^ pat_q) & mask) == '0);
  assign novl_clr = y & (ovl_q == SEQ_NOVL);

  seq_hist_reg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (cfg_load),
    .novl_clr (novl_clr),
    .bit_in   (in),
    .hist     (hist),
    .fill     (fill)
  );

`ifdef SEQ_DETECT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (y && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
